// File: rtl/fifo_spi_tx.sv
// FIFO drain stage: pops one word at a time and shifts it out MSB-first as an
// SPI mode-0 master, capturing MISO in full duplex.
module fifo_spi_tx #(
    parameter int FIFO_WIDTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss_n,
    output logic                  busy,
    output logic [FIFO_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [2:0]            dbg_state_o
);

    localparam int BIT_W = $clog2(FIFO_WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [FIFO_WIDTH-1:0]   tx_sr_q;
    logic [FIFO_WIDTH-1:0]   rx_sr_q;
    logic [FIFO_WIDTH-1:0]   rx_data_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic                    sclk_q;
    logic                    ss_n_q;
    logic                    busy_q;
    logic                    rd_en_q;
    logic                    rx_valid_q;
    logic                    div_tc;

    assign div_tc = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_READ: begin
                    state_q <= ST_LOAD;
                    rd_en_q <= 1'b0;
                end
                ST_LOAD: begin
                    tx_sr_q   <= fifo_data_out;
                    bit_cnt_q <= '0;
                    div_cnt_q <= '0;
                    ss_n_q    <= 1'b0;
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        if (!sclk_q) begin
                            // Rising edge: sample MISO while MOSI is stable.
                            rx_sr_q   <= {rx_sr_q[FIFO_WIDTH-2:0], miso};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == BIT_W'(FIFO_WIDTH)) begin
                            rx_data_q  <= rx_sr_q;
                            rx_valid_q <= 1'b1;
                            ss_n_q     <= 1'b1;
                            gap_cnt_q  <= '0;
                            state_q    <= ST_GAP;
                        end else begin
                            tx_sr_q <= {tx_sr_q[FIFO_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_en_q <= 1'b0;
                    ss_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en  = rd_en_q;
    assign sclk        = sclk_q;
    assign mosi        = tx_sr_q[FIFO_WIDTH-1];
    assign ss_n        = ss_n_q;
    assign busy        = busy_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Bench for fifo_spi_tx: queue-backed FIFO, SPI slave and per-word scoreboard
// built from the word-level rules (bit order, frame lengths, gaps).
module tb_fifo_spi_tx;

    localparam int W        = 16;
    localparam int CD       = 2;
    localparam int GAP      = 2;
    localparam int SS_LOW   = 2 * CD * W;
    localparam int WORD_CYC = 3 + SS_LOW + GAP;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data_out;
    logic         fifo_rd_en;
    logic         miso;
    logic         sclk;
    logic         mosi;
    logic         ss_n;
    logic         busy;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic [2:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // stimulus-side controls (written by the initial block only)
    logic         model_on;
    logic         loopback;
    logic         rnd_empty;
    logic [W-1:0] rnd_data;
    logic         rnd_miso;
    logic [W-1:0] fifo_q[$];

    // model-side state (written by the negedge block only)
    logic         mdl_empty = 1'b1;
    logic [W-1:0] mdl_data = '0;
    logic         pend = 1'b0;
    logic [W-1:0] pend_word;
    bit           underflow = 1'b0;
    logic         slave_bit = 1'b0;
    logic [W-1:0] slave_sr, cur_tx, cur_rx, mosi_word, last_mosi_word;
    logic [W-1:0] tx_exp_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_log_q[$];
    int           rd_cyc_q[$];
    int           gap_q[$];
    int           busy_len_q[$];
    int           cyc = 0, rd_cnt = 0, rxv_cnt = 0;
    int           ss_lo = 0, ss_hi = 0, rise_cnt = 0, busy_run = 0;
    bit           in_word = 1'b0, seen_end = 1'b0;
    logic         prev_ss, prev_sclk, prev_mosi, prev_rd, prev_rxv, prev_busy;
    logic [W-1:0] prev_rx;

    assign fifo_empty    = model_on ? mdl_empty : rnd_empty;
    assign fifo_data_out = model_on ? mdl_data : rnd_data;
    assign miso          = loopback ? mosi : (model_on ? slave_bit : rnd_miso);

    fifo_spi_tx #(.FIFO_WIDTH(W), .CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .miso          (miso),
        .sclk          (sclk),
        .mosi          (mosi),
        .ss_n          (ss_n),
        .busy          (busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor, slave and FIFO model, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            tx_exp_q.delete();
            exp_q.delete();
            pend     = 1'b0;
            in_word  = 1'b0;
            seen_end = 1'b0;
            ss_lo    = 0;
            ss_hi    = 0;
            busy_run = 0;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
                check_eq("rd_single", prev_rd, 1'b0);
            end
            if (mosi !== prev_mosi)
                check_eq("mosi_edge", (prev_sclk && !sclk) || (prev_ss && !ss_n), 1);
            if (!ss_n) begin
                check_eq("busy_in_word", busy, 1'b1);
                if (prev_ss) begin
                    if (seen_end) gap_q.push_back(ss_hi);
                    check_eq("tx_queued", tx_exp_q.size() != 0, 1);
                    in_word   = (tx_exp_q.size() != 0);
                    cur_tx    = in_word ? tx_exp_q.pop_front() : '0;
                    cur_rx    = loopback ? cur_tx : W'($urandom);
                    slave_sr  = cur_rx;
                    exp_q.push_back(cur_rx);
                    ss_lo     = 0;
                    rise_cnt  = 0;
                    mosi_word = '0;
                end
                ss_lo++;
                if (sclk && !prev_sclk) begin
                    mosi_word = {mosi_word[W-2:0], mosi};
                    rise_cnt++;
                end
                if (!sclk && prev_sclk) slave_sr = slave_sr << 1;
                slave_bit = slave_sr[W-1];
            end else begin
                if (!prev_ss) begin
                    check_eq("ss_low_len", ss_lo, SS_LOW);
                    check_eq("sclk_rises", rise_cnt, W);
                    if (in_word) check_eq("mosi_word", mosi_word, cur_tx);
                    last_mosi_word = mosi_word;
                    in_word  = 1'b0;
                    seen_end = 1'b1;
                    ss_hi    = 0;
                end
                ss_hi++;
                check_eq("sclk_idle", sclk, 1'b0);
            end
            if (rx_valid) begin
                rxv_cnt++;
                rx_log_q.push_back(rx_data);
                check_eq("rxv_first_gap", {prev_ss, ss_n}, 2'b01);
                check_eq("rxv_width", prev_rxv, 1'b0);
                check_eq("rx_pending", exp_q.size(), 1);
                if (exp_q.size() != 0) check_eq("rx_data", rx_data, exp_q.pop_front());
            end else if (rx_data !== prev_rx) begin
                check_eq("rx_hold", rx_data, prev_rx);
            end
            if (busy) begin
                busy_run++;
            end else if (prev_busy) begin
                busy_len_q.push_back(busy_run);
                busy_run = 0;
            end
        end
        prev_ss   = ss_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_rd   = fifo_rd_en;
        prev_rxv  = rx_valid;
        prev_busy = busy;
        prev_rx   = rx_data;
        // FIFO: read data appears the cycle after the strobe, garbage otherwise.
        if (pend) begin
            mdl_data = pend_word;
            pend     = 1'b0;
        end else begin
            mdl_data = W'($urandom);
        end
        if (rst_n && model_on && fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                underflow = 1'b1;
            end else begin
                pend_word = fifo_q.pop_front();
                tx_exp_q.push_back(pend_word);
                pend = 1'b1;
            end
        end
        mdl_empty = (fifo_q.size() == 0);
    end

    task automatic wait_drained(input int max_cyc);
        int n = 0;
        while ((fifo_q.size() != 0 || busy || fifo_rd_en) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", n < max_cyc, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ss_low(input int max_cyc);
        int n = 0;
        while (ss_n && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("ss_low_timeout", n < max_cyc, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", n < max_cyc, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ss_n"}, ss_n, 1'b1);
        check_eq({tag, "_sclk"}, sclk, 1'b0);
        check_eq({tag, "_mosi"}, mosi, 1'b0);
        check_eq({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_rx_valid"}, rx_valid, 1'b0);
        check_eq({tag, "_rx_data"}, rx_data, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, rx0, g0, b0, pushed, nw;
        logic [W-1:0] w1, w2;
        bit any_rd, any_ss, any_busy;

        rst_n = 1'b0; enable = 1'b0; model_on = 1'b0; loopback = 1'b0;
        rnd_empty = 1'b1; rnd_data = '0; rnd_miso = 1'b0;

        // reset held with random inputs
        repeat (8) begin
            @(posedge clk); #1;
            enable = 1'($urandom); rnd_empty = 1'($urandom);
            rnd_data = W'($urandom); rnd_miso = 1'($urandom);
            check_eq("rst_hold_rd_en", fifo_rd_en, 1'b0);
        end
        check_reset_outputs("rst");
        enable = 1'b0; model_on = 1'b1; loopback = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // single word, looped back
        rd0 = rd_cnt; rx0 = rxv_cnt; b0 = busy_len_q.size();
        fifo_q.push_back(16'hA5C3); enable = 1'b1;
        wait_drained(400);
        check_eq("single_rd_pulses", rd_cnt - rd0, 1);
        check_eq("single_rx_pulses", rxv_cnt - rx0, 1);
        check_eq("single_rx_data", rx_data, 16'hA5C3);
        check_eq("single_mosi_seq", last_mosi_word, 16'hA5C3);
        check_eq("single_busy_runs", busy_len_q.size() - b0, 1);
        if (busy_len_q.size() > b0) check_eq("single_busy_len", busy_len_q[b0], WORD_CYC - 1);

        // three back-to-back words
        @(posedge clk); #1;
        rd0 = rd_cyc_q.size(); g0 = gap_q.size(); rx0 = rx_log_q.size();
        fifo_q.push_back(16'h0001); fifo_q.push_back(16'h8000); fifo_q.push_back(16'hFFFF);
        wait_drained(600);
        check_eq("b2b_rd_count", rd_cyc_q.size() - rd0, 3);
        if (rd_cyc_q.size() - rd0 == 3) begin
            check_eq("b2b_rd_space0", rd_cyc_q[rd0+1] - rd_cyc_q[rd0], WORD_CYC);
            check_eq("b2b_rd_space1", rd_cyc_q[rd0+2] - rd_cyc_q[rd0+1], WORD_CYC);
        end
        check_eq("b2b_gap_count", gap_q.size() - g0, 3);
        if (gap_q.size() - g0 == 3) begin
            check_eq("b2b_ss_high0", gap_q[g0+1], GAP + 3);
            check_eq("b2b_ss_high1", gap_q[g0+2], GAP + 3);
        end
        check_eq("b2b_rx_count", rx_log_q.size() - rx0, 3);
        if (rx_log_q.size() - rx0 == 3) begin
            check_eq("b2b_rx0", rx_log_q[rx0], 16'h0001);
            check_eq("b2b_rx1", rx_log_q[rx0+1], 16'h8000);
            check_eq("b2b_rx2", rx_log_q[rx0+2], 16'hFFFF);
        end

        // empty FIFO with enable high
        @(posedge clk); #1;
        any_rd = 0; any_ss = 0; any_busy = 0;
        repeat (100) begin
            @(negedge clk);
            any_rd |= fifo_rd_en; any_ss |= !ss_n; any_busy |= busy;
        end
        check_eq("empty_rd_en", any_rd, 1'b0);
        check_eq("empty_ss_n", any_ss, 1'b0);
        check_eq("empty_busy", any_busy, 1'b0);
        check_eq("empty_underflow", underflow, 1'b0);

        // enable dropped mid-word, random MISO
        @(posedge clk); #1;
        loopback = 1'b0; rd0 = rd_cnt; rx0 = rxv_cnt;
        fifo_q.push_back(W'($urandom)); fifo_q.push_back(W'($urandom));
        wait_ss_low(50);
        repeat (10) @(posedge clk); #1;
        enable = 1'b0;
        wait_idle(200);
        repeat (100) @(negedge clk);
        check_eq("endrop_rd_pulses", rd_cnt - rd0, 1);
        check_eq("endrop_rx_pulses", rxv_cnt - rx0, 1);
        check_eq("endrop_fifo_left", fifo_q.size(), 1);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_drained(300);
        check_eq("endrop_rd_total", rd_cnt - rd0, 2);
        check_eq("endrop_rx_total", rxv_cnt - rx0, 2);

        // reset pulsed mid-word
        @(posedge clk); #1;
        loopback = 1'b1; rd0 = rd_cnt; rx0 = rxv_cnt;
        w1 = W'($urandom); w2 = W'($urandom);
        fifo_q.push_back(w1); fifo_q.push_back(w2);
        wait_ss_low(50);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        wait_drained(300);
        check_eq("abort_rd_total", rd_cnt - rd0, 2);
        check_eq("abort_rx_pulses", rxv_cnt - rx0, 1);
        check_eq("abort_rx_data", rx_data, w2);
        check_eq("abort_mosi_word", last_mosi_word, w2);

        // randomized traffic with enable toggling
        rd0 = rd_cnt; rx0 = rxv_cnt; pushed = 0;
        for (int it = 0; it < 15; it++) begin
            @(posedge clk); #1;
            loopback = 1'($urandom);
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) fifo_q.push_back(W'($urandom));
            pushed += nw;
            enable = 1'($urandom);
            repeat ($urandom_range(0, 120)) @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                fifo_q.push_back(W'($urandom));
                pushed++;
            end
            enable = 1'($urandom);
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
            enable = 1'b1;
            wait_drained(1000);
        end
        check_eq("rand_rd_total", rd_cnt - rd0, pushed);
        check_eq("rand_rx_total", rxv_cnt - rx0, pushed);
        check_eq("final_underflow", underflow, 1'b0);
        check_eq("final_tx_left", tx_exp_q.size(), 0);
        check_eq("final_rx_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
